// File: rtl/dense_layer_sequencer.sv
// Frame-level controller for one dense layer: gathers a serial input vector, runs the
// fixed-latency datapath once, then streams the neuron results back out one word at a time.
`timescale 1ns/1ps

module dense_layer_sequencer #(
    parameter int WIDTH       = 16,
    parameter int NFRAC       = 10,
    parameter int INPUT_SIZE  = 128,
    parameter int OUTPUT_SIZE = 10,
    parameter int LATENCY     = 8
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_last,

    output logic [0:INPUT_SIZE-1][WIDTH-1:0]    dp_input,
    output logic                                dp_reset_tree,
    input  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]   dp_output,

    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic [$clog2(OUTPUT_SIZE)-1:0]      out_index,
    output logic                                out_last,

    output logic                                busy,
    output logic                                err_len
);

    localparam int CW = $clog2(INPUT_SIZE);
    localparam int OW = $clog2(OUTPUT_SIZE);
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Elaboration-time guard on the parameter ranges the sequencing relies on.
    if (INPUT_SIZE < 2 || OUTPUT_SIZE < 2 || LATENCY < 1 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_params
        $error("dense_layer_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t                             r_state;
    logic [CW-1:0]                      r_cnt;
    logic [WW-1:0]                      r_wcnt;
    logic [OW-1:0]                      r_ocnt;
    logic [0:INPUT_SIZE-1][WIDTH-1:0]   r_hold;
    logic [0:OUTPUT_SIZE-1][WIDTH-1:0]  r_res;

    logic                               r_in_ready;
    logic                               r_dp_reset_tree;
    logic                               r_out_valid;
    logic [WIDTH-1:0]                   r_out_data;
    logic                               r_out_last;
    logic                               r_busy;
    logic                               r_err_len;

    logic                               w_in_hs;
    logic                               w_out_hs;
    logic                               w_cnt_last;
    logic                               w_wait_done;
    logic [OW-1:0]                      w_ocnt_next;

    assign in_ready      = r_in_ready & ~reset;
    assign w_in_hs       = in_valid & in_ready;
    assign w_out_hs      = r_out_valid & out_ready;
    assign w_cnt_last    = (r_cnt == CW'(INPUT_SIZE - 1));
    assign w_wait_done   = (r_wcnt == WW'(LATENCY - 1));
    assign w_ocnt_next   = r_ocnt + OW'(1);

    assign dp_input      = r_hold;
    assign dp_reset_tree = r_dp_reset_tree;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_index     = r_ocnt;
    assign out_last      = r_out_last;
    assign busy          = r_busy;
    assign err_len       = r_err_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_LOAD;
            r_cnt           <= '0;
            r_wcnt          <= '0;
            r_ocnt          <= '0;
            // NOTE: hold and res are cleared here because dp_input must read zero after reset;
            // a pure storage array would normally be left out of the reset.
            r_hold          <= '0;
            r_res           <= '0;
            r_in_ready      <= 1'b0;
            r_dp_reset_tree <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_last      <= 1'b0;
            r_busy          <= 1'b0;
            r_err_len       <= 1'b0;
        end else begin
            r_err_len       <= 1'b0;
            r_dp_reset_tree <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_hs) begin
                        r_hold[r_cnt] <= in_data;
                        if (w_cnt_last) begin
                            // A full vector always proceeds; a missing last is only flagged.
                            r_cnt           <= '0;
                            r_wcnt          <= '0;
                            r_err_len       <= ~in_last;
                            r_in_ready      <= 1'b0;
                            r_busy          <= 1'b1;
                            r_dp_reset_tree <= 1'b1;
                            r_state         <= S_COMPUTE;
                        end else if (in_last) begin
                            r_cnt     <= '0;
                            r_err_len <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end

                S_COMPUTE: begin
                    if (w_wait_done) begin
                        for (int j = 0; j < OUTPUT_SIZE; j++) begin
                            r_res[j] <= dp_output[OUTPUT_SIZE-1-j];
                        end
                        // res is written on this same edge, so the first word comes straight from the datapath.
                        r_out_data  <= dp_output[OUTPUT_SIZE-1];
                        r_ocnt      <= '0;
                        r_out_last  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_wcnt <= r_wcnt + WW'(1);
                    end
                end

                S_DRAIN: begin
                    if (w_out_hs) begin
                        if (r_out_last) begin
                            r_ocnt      <= '0;
                            r_out_last  <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_LOAD;
                        end else begin
                            r_ocnt     <= w_ocnt_next;
                            r_out_data <= r_res[w_ocnt_next];
                            r_out_last <= (w_ocnt_next == OW'(OUTPUT_SIZE - 1));
                        end
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer with a small summing datapath model
// (dp_output[2-j] = sum(dp_input) + j, one register stage behind a settled dp_input).
`timescale 1ns/1ps

module tb_dense_layer_sequencer;

    localparam int WIDTH  = 16;
    localparam int NFRAC  = 10;
    localparam int IN_SZ  = 4;
    localparam int OUT_SZ = 3;
    localparam int LAT    = 2;
    localparam int OW     = $clog2(OUT_SZ);

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               in_data;
    logic                           in_last;
    logic [0:IN_SZ-1][WIDTH-1:0]    dp_input;
    logic                           dp_reset_tree;
    logic [OUT_SZ-1:0][WIDTH-1:0]   dp_output;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               out_data;
    logic [OW-1:0]                  out_index;
    logic                           out_last;
    logic                           busy;
    logic                           err_len;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dense_layer_sequencer #(
        .WIDTH(WIDTH), .NFRAC(NFRAC), .INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .dp_input(dp_input), .dp_reset_tree(dp_reset_tree), .dp_output(dp_output),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .busy(busy), .err_len(err_len)
    );

    // Datapath model: results are valid LAT cycles after dp_input settles.
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_dp_sum;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < IN_SZ; i++) w_sum = w_sum + dp_input[i];
    end

    always_ff @(posedge clk) r_dp_sum <= w_sum;

    always_comb begin
        dp_output = '0;
        for (int j = 0; j < OUT_SZ; j++) dp_output[OUT_SZ-1-j] = r_dp_sum + WIDTH'(j);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input int data, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = WIDTH'(data);
        in_last  = last;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_out_valid_timeout"}, out_valid, 1);
    endtask

    task automatic drain(input string tag, input int base);
        for (int j = 0; j < OUT_SZ; j++) begin
            check($sformatf("%s_valid%0d", tag, j), out_valid, 1);
            check($sformatf("%s_index%0d", tag, j), out_index, j);
            check($sformatf("%s_data%0d", tag, j), out_data, base + j);
            check($sformatf("%s_last%0d", tag, j), out_last, (j == OUT_SZ - 1));
            tick();
        end
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_words;
        int last_hs_cyc;
        int f2_first_cyc;
        int viol;
        int firsts[$];

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
        check("rst_dp_reset_tree", dp_reset_tree, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_dp_input", dp_input, 0);
        reset = 1'b0;
        check("rst_release_in_ready", in_ready, 0);
        tick();
        check("load_in_ready", in_ready, 1);

        // Nominal frame: exact latency of every milestone.
        out_ready = 1'b1;
        send("nom0", 1, 0);
        send("nom1", 2, 0);
        send("nom2", 3, 0);
        send("nom3", 4, 1);
        check("nom_tree_t1", dp_reset_tree, 1);
        check("nom_busy_t1", busy, 1);
        check("nom_in_ready_t1", in_ready, 0);
        check("nom_err_t1", err_len, 0);
        check("nom_dp_input", dp_input, {16'd1, 16'd2, 16'd3, 16'd4});
        tick();
        check("nom_tree_t2", dp_reset_tree, 0);
        check("nom_valid_t2", out_valid, 0);
        tick();
        check("nom_valid_t3", out_valid, 1);
        drain("nom", 10);
        check("nom_busy_done", busy, 0);

        // Backpressure at index 1.
        send("bp0", 1, 0);
        send("bp1", 2, 0);
        send("bp2", 3, 0);
        send("bp3", 4, 1);
        wait_out("bp");
        check("bp_idx0", out_index, 0);
        check("bp_data0", out_data, 10);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_stall_idx%0d", k), out_index, 1);
            check($sformatf("bp_stall_data%0d", k), out_data, 11);
            check($sformatf("bp_stall_valid%0d", k), out_valid, 1);
            check($sformatf("bp_stall_last%0d", k), out_last, 0);
            tick();
        end
        check("bp_dp_input_stable", dp_input, {16'd1, 16'd2, 16'd3, 16'd4});
        out_ready = 1'b1;
        check("bp_resume_idx", out_index, 1);
        check("bp_resume_data", out_data, 11);
        tick();
        check("bp_idx2", out_index, 2);
        check("bp_data2", out_data, 12);
        check("bp_last2", out_last, 1);
        tick();
        check("bp_valid_after", out_valid, 0);

        // Early last on the second word.
        send("el0", 10, 0);
        send("el1", 20, 1);
        check("el_err", err_len, 1);
        check("el_busy", busy, 0);
        check("el_ready", in_ready, 1);
        tick();
        check("el_err_clear", err_len, 0);
        check("el_busy_still", busy, 0);
        send("el_f0", 5, 0);
        send("el_f1", 5, 0);
        send("el_f2", 5, 0);
        send("el_f3", 5, 1);
        check("el_f_err", err_len, 0);
        wait_out("el_f");
        drain("el_f", 20);

        // Missing last: flagged but still processed.
        send("ml0", 1, 0);
        send("ml1", 1, 0);
        send("ml2", 1, 0);
        send("ml3", 2, 0);
        check("ml_err", err_len, 1);
        check("ml_busy", busy, 1);
        tick();
        check("ml_err_clear", err_len, 0);
        wait_out("ml");
        drain("ml", 5);

        // Reset in DRAIN after index 0 has been sent.
        send("mr0", 1, 0);
        send("mr1", 2, 0);
        send("mr2", 3, 0);
        send("mr3", 4, 1);
        wait_out("mr");
        tick();
        check("mr_idx1_before", out_index, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_out_valid", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_in_ready", in_ready, 0);
        check("mr_dp_input", dp_input, 0);
        tick();
        check("mr_in_ready_next", in_ready, 1);

        // Back-to-back frames with in_valid held high.
        acc_words = 0; last_hs_cyc = -1; f2_first_cyc = -1; viol = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (acc_words < 8);
            in_data  = WIDTH'(acc_words + 1);
            in_last  = (acc_words % 4 == 3);
            if (busy && in_ready) viol++;
            if (out_valid && out_ready && out_index == 0) firsts.push_back(int'(out_data));
            if (out_valid && out_ready && out_last && last_hs_cyc < 0) last_hs_cyc = cyc;
            if (in_valid && in_ready && acc_words == 4 && f2_first_cyc < 0) f2_first_cyc = cyc;
            if (in_valid && in_ready) acc_words++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("b2b_ready_gated", viol, 0);
        check("b2b_words", acc_words, 8);
        check("b2b_gap", f2_first_cyc - last_hs_cyc, 1);
        check("b2b_nframes", firsts.size(), 2);
        if (firsts.size() == 2) begin
            check("b2b_f1_first", firsts[0], 10);
            check("b2b_f2_first", firsts[1], 26);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
